// File: rtl/bcd_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder_pkg
//  Description : Shared state encoding, BCD constants and digit helper for
//                the digit-serial BCD adder/subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_serial_adder_pkg;

    // Sequencer states: idle/accepting, digit processing, result strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest legal BCD digit and the decimal-adjust offset
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // True when a 4-bit nibble is not a legal BCD digit
    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage : bcd_serial_adder_pkg
`default_nettype wire

// File: rtl/bcd_serial_adder_digit_add.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_add
//  Description : Single-digit BCD adder with decimal carry in/out. Binary sum
//                above 9 is adjusted by +6 modulo 16 and raises the carry.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] w_raw;

    // Binary add then decimal adjust; the +6 wraps within the nibble
    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
        if (w_raw > {1'b0, BCD_MAX}) begin
            s     = w_raw[3:0] + BCD_CORR;
            c_out = 1'b1;
        end else begin
            s     = w_raw[3:0];
            c_out = 1'b0;
        end
    end

endmodule : bcd_digit_add
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder
//  Description : Digit-serial packed-BCD adder/subtractor. One digit per
//                clock, LSD first, start/ready/done handshake. Subtraction is
//                A + nines-complement(B) + 1; cout then reports the borrow.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic               r_sub;
    logic               r_carry;
    logic               r_err_int;
    logic [IDX_W-1:0]   r_idx;

    logic [3:0]         w_a_dig;
    logic [3:0]         w_b_dig;
    logic [3:0]         w_b_eff;
    logic [3:0]         w_dig;
    logic               w_c_out;
    logic               w_in_err;
    logic [W-1:0]       w_res_next;

    // Select the current digit pair and nines-complement B when subtracting
    always_comb begin
        w_a_dig = r_a[{r_idx, 2'b00} +: 4];
        w_b_dig = r_b[{r_idx, 2'b00} +: 4];
        w_b_eff = r_sub ? (BCD_MAX - w_b_dig) : w_b_dig;
    end

    // Single time-shared digit adder
    bcd_digit_add u_digit_add (
        .a     (w_a_dig),
        .b     (w_b_eff),
        .c_in  (r_carry),
        .s     (w_dig),
        .c_out (w_c_out)
    );

    // Result with the current digit merged in, so the last digit can be
    // published in the same edge that enters DONE
    always_comb begin
        w_res_next = r_res;
        w_res_next[{r_idx, 2'b00} +: 4] = w_dig;
    end

    // Flag any non-BCD nibble on the incoming operands
    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a[4*i +: 4]) || digit_invalid(b[4*i +: 4])) begin
                w_in_err = 1'b1;
            end
        end
    end

    // Sequencer with registered handshake and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_err_int <= 1'b0;
            r_idx     <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_sub     <= sub;
                        r_carry   <= sub ? 1'b1 : cin;
                        r_idx     <= '0;
                        r_err_int <= w_in_err;
                        r_state   <= ST_RUN;
                        ready     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_c_out;
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        if (r_err_int) begin
                            sum  <= '0;
                            cout <= 1'b0;
                            err  <= 1'b1;
                        end else begin
                            sum  <= w_res_next;
                            cout <= r_sub ? ~w_c_out : w_c_out;
                            err  <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule : bcd_serial_adder
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_adder
//  Description : Scoreboard bench for bcd_serial_adder (DIGITS=4). Stimulus
//                pushes hand-computed results; a negedge monitor pops and
//                compares on every done pulse, including done latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          reset;
    logic          start;
    logic          sub;
    logic          cin;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 sum=%h, expected no pending result", sum);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_sum"},     32'(sum),  32'(e.sum));
                chk({e.name, "_cout"},    32'(cout), 32'(e.cout));
                chk({e.name, "_err"},     32'(err),  32'(e.err));
                chk({e.name, "_latency"}, 32'(cyc - e.cyc), 32'(DIGITS + 1));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic push(input logic [W-1:0] es, input logic ec, input logic ee, input string nm);
        exp_t e;
        e.sum = es; e.cout = ec; e.err = ee; e.cyc = cyc; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic ee,
                          input string nm, input bit chk_rdy);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
            push(es, ec, ee, nm);
            @(negedge clk);
            start = 1'b0;
            // scramble inputs: only the latched copies may matter
            a = W'($urandom); b = W'($urandom); cin = ~tc; sub = 1'b0;
            if (chk_rdy) begin
                for (int i = 1; i <= DIGITS + 1; i++) begin
                    chk({nm, "_ready_low"}, 32'(ready), 32'd0);
                    @(negedge clk);
                end
                chk({nm, "_ready_high"}, 32'(ready), 32'd1);
            end
        end
    endtask

    initial begin
        bit ok;
        int k0;
        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_sum",   32'(sum),   32'd0);
        chk("rst_cout",  32'(cout),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic add with ready profile
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, "add", 1'b1);

        // Reset in flight: aborts, clears outputs, no done pulse
        wait_ready(ok);
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done",  32'(done),  32'd0);
        chk("midrst_sum",   32'(sum),   32'd0);
        chk("midrst_cout",  32'(cout),  32'd0);
        chk("midrst_err",   32'(err),   32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Carry ripple
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple1", 1'b0);
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "ripple2", 1'b0);

        // Subtract, with and without borrow (cin ignored)
        run_op(16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b0, 1'b0, "sub1", 1'b0);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b1, 1'b0, "sub2", 1'b0);

        // Invalid digit, then a valid add clears err
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, "baddig", 1'b1);
        run_op(16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, "clrerr", 1'b0);

        // start pulsed during RUN must be ignored
        wait_ready(ok);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        push(16'h3333, 1'b0, 1'b0, "ignore");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h4444; b = 16'h4444; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // start held high: back-to-back acceptance right after done
        wait_ready(ok);
        a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
        k0 = cyc;
        push(16'h0003, 1'b0, 1'b0, "held1");
        @(negedge clk);
        a = 16'h0010; b = 16'h0020;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        chk("held_reaccept_cycle", 32'(cyc - k0), 32'(DIGITS + 2));
        push(16'h0030, 1'b0, 1'b0, "held2");
        @(negedge clk);
        start = 1'b0;

        // Drain
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bcd_serial_adder
`default_nettype wire
